// File: rtl/fb_pkg.sv
// fb_pkg -- shared types and defaults for the filter-bank scheduler.
//   fb_state_t : scheduler FSM state encoding (IDLE, RUN, LATCH)
//   phase_t    : 6-bit tap/coefficient index
//   FB_PHASES_DEF / FB_NUM_BANDS_DEF : default parameter values
package fb_pkg;

    localparam int FB_PHASES_DEF    = 58;
    localparam int FB_NUM_BANDS_DEF = 16;
    localparam int FB_PHASE_W       = 6;

    typedef logic [FB_PHASE_W-1:0] phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LATCH = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_phase_cnt.sv
// fb_phase_cnt -- enabled modulo-MOD counter with terminal flag.
// Ports:
//   clock    : rising-edge clock
//   reset    : synchronous active-low reset (count -> 0)
//   clear    : synchronous clear to 0 (wins over en)
//   en       : advance by one; wraps MOD-1 -> 0
//   count    : current value
//   terminal : count == MOD-1
module fb_phase_cnt
    import fb_pkg::*;
#(
    parameter int MOD = FB_PHASES_DEF
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    output logic [FB_PHASE_W-1:0] count,
    output logic                  terminal
);

    localparam phase_t LAST = phase_t'(MOD - 1);

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= terminal ? '0 : count + phase_t'(1);
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/fb_sched.sv
// fb_sched -- sequencer for a serial-MAC filter bank.
// One accepted sample produces: a shift_en pulse, PHASES accumulate cycles
// (acc_clear on phase 0), then a one-cycle result_latch. The band outputs are
// then offered with out_valid until out_ready takes them.
//
// Handshakes: an input sample transfers on a cycle where in_valid & in_ready &
// clk_enable are all 1; a result set transfers on a cycle where
// out_valid & out_ready & clk_enable are all 1. in_valid is ignored while the
// scheduler is busy (RUN/LATCH).
//
// Ports:
//   clock, reset (sync, active-low), clk_enable (global advance qualifier)
//   in_valid / in_ready     : sample handshake
//   shift_en                : advance the shared delay pipeline
//   phase [5:0]             : tap/coefficient index
//   acc_clear, acc_en[]     : accumulator controls
//   result_latch            : band output registers capture accumulators
//   out_valid / out_ready   : result-set handshake
//   overrun                 : sticky, an unconsumed result set was overwritten
//   band_mask[] (only with FB_SCHED_BAND_MASK_EN) : per-sample band enable
//   state_dbg [1:0]         : current FSM state (fb_state_t encoding)
module fb_sched
    import fb_pkg::*;
#(
    parameter int PHASES    = FB_PHASES_DEF,
    parameter int NUM_BANDS = FB_NUM_BANDS_DEF
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clk_enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 shift_en,
    output logic [5:0]           phase,
    output logic                 acc_clear,
    output logic [NUM_BANDS-1:0] acc_en,
    output logic                 result_latch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
`ifdef FB_SCHED_BAND_MASK_EN
    input  logic [NUM_BANDS-1:0] band_mask,
`endif
    output logic [1:0]           state_dbg
);

    fb_state_t            state, state_nxt;
    logic                 accept;
    logic                 cnt_en;
    logic                 cnt_last;
    logic [NUM_BANDS-1:0] band_en;

    // Phase counter: cleared on accept, advanced through RUN, but never
    // advanced on its terminal count so phase holds PHASES-1 until the next
    // sample arrives.
    fb_phase_cnt #(
        .MOD (PHASES)
    ) u_phase_cnt (
        .clock    (clock),
        .reset    (reset),
        .clear    (accept),
        .en       (cnt_en),
        .count    (phase),
        .terminal (cnt_last)
    );

`ifdef FB_SCHED_BAND_MASK_EN
    // Mask is captured with the sample so it stays stable for the whole run.
    always_ff @(posedge clock) begin
        if (!reset) begin
            band_en <= '1;
        end else if (accept) begin
            band_en <= band_mask;
        end
    end
`else
    assign band_en = '1;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else if (clk_enable) begin
            state <= state_nxt;
        end
    end

    // Strobes are only ever raised with clk_enable high, so a stalled cycle
    // leaves the datapath untouched.
    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        shift_en     = 1'b0;
        acc_clear    = 1'b0;
        acc_en       = '0;
        result_latch = 1'b0;
        accept       = 1'b0;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && clk_enable) begin
                    accept    = 1'b1;
                    shift_en  = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clk_enable) begin
                    acc_en    = band_en;
                    acc_clear = (phase == '0);
                    if (cnt_last) begin
                        state_nxt = ST_LATCH;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (clk_enable) begin
                    result_latch = 1'b1;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A new result set always wins over a same-cycle consume: out_valid stays
    // set. Overrun is only flagged when the old set was not being taken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (clk_enable) begin
            if (result_latch) begin
                out_valid <= 1'b1;
                if (out_valid && !out_ready) begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_fb_sched.sv
`timescale 1ns/1ps
module tb_fb_sched;

    localparam int          PHASES = 58;
    localparam int          NB     = 16;
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_RUN   = 2'd1;
    localparam logic [1:0]  S_LATCH = 2'd2;
    localparam logic [NB-1:0] ALL_ON = {NB{1'b1}};

    // ---------------- clock / reset / DUT ----------------
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clk_enable = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          shift_en;
    logic [5:0]    phase;
    logic          acc_clear;
    logic [NB-1:0] acc_en;
    logic          result_latch;
    logic          out_valid;
    logic          overrun;
    logic [1:0]    state_dbg;
`ifdef FB_SCHED_BAND_MASK_EN
    logic [NB-1:0] band_mask = {NB{1'b1}};
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;

    fb_sched #(
        .PHASES    (PHASES),
        .NUM_BANDS (NB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .shift_en     (shift_en),
        .phase        (phase),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .result_latch (result_latch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
`ifdef FB_SCHED_BAND_MASK_EN
        .band_mask    (band_mask),
`endif
        .state_dbg    (state_dbg)
    );

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    // Accept one sample and stop on the result_latch cycle; t is the number
    // of clocks from the accept cycle (t=0) to the latch cycle (200 = timeout).
    task automatic start_and_wait(output int t);
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        t = 1;
        #1;
        while (result_latch !== 1'b1 && t < 200) begin
            tick();
            t++;
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        #1;
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, S_IDLE); end
        n_checks++; if (phase !== 6'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if ({shift_en, acc_clear, result_latch, acc_en} !== '0) begin n_fail++; $display("FAIL reset_strobes: got %b%b%b %h expected all 0", shift_en, acc_clear, result_latch, acc_en); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL single_shift_en: got %b expected 1", shift_en); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready_idle: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int p = 0; p < PHASES; p++) begin
            // in_valid pokes during RUN must be ignored
            in_valid = (p >= 5 && p <= 7);
            #1;
            n_checks++; if (state_dbg !== S_RUN) begin n_fail++; $display("FAIL single_state_run p=%0d: got %0d expected %0d", p, state_dbg, S_RUN); end
            n_checks++; if (phase !== 6'(p)) begin n_fail++; $display("FAIL single_phase: got %0d expected %0d", phase, p); end
            n_checks++; if (in_ready !== 1'b0 || shift_en !== 1'b0) begin n_fail++; $display("FAIL single_busy p=%0d: in_ready=%b shift_en=%b expected 0 0", p, in_ready, shift_en); end
            n_checks++; if (acc_en !== ALL_ON) begin n_fail++; $display("FAIL single_acc_en p=%0d: got %h expected %h", p, acc_en, ALL_ON); end
            n_checks++; if (acc_clear !== (p == 0)) begin n_fail++; $display("FAIL single_acc_clear p=%0d: got %b expected %b", p, acc_clear, (p == 0)); end
            n_checks++; if (result_latch !== 1'b0) begin n_fail++; $display("FAIL single_early_latch p=%0d: got %b expected 0", p, result_latch); end
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_checks++; if (state_dbg !== S_LATCH || result_latch !== 1'b1) begin n_fail++; $display("FAIL single_latch: state=%0d latch=%b expected %0d 1", state_dbg, result_latch, S_LATCH); end
        n_checks++; if (acc_en !== '0 || acc_clear !== 1'b0) begin n_fail++; $display("FAIL single_latch_acc: acc_en=%h clr=%b expected 0 0", acc_en, acc_clear); end
        n_checks++; if (phase !== 6'(PHASES - 1)) begin n_fail++; $display("FAIL single_latch_phase: got %0d expected %0d", phase, PHASES - 1); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_early: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid_set: got %b expected 1", out_valid); end
        n_checks++; if (state_dbg !== S_IDLE || result_latch !== 1'b0) begin n_fail++; $display("FAIL single_back_idle: state=%0d latch=%b expected 0 0", state_dbg, result_latch); end
        n_checks++; if (phase !== 6'(PHASES - 1)) begin n_fail++; $display("FAIL single_no_wrap: got %0d expected %0d", phase, PHASES - 1); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_consume: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int latches;
        latches = 0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k * (PHASES + 2)));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c <= 3 * (PHASES + 2); c++) begin
            #1;
            if (shift_en === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_shift: unexpected shift_en at cycle %0d", c);
                end else if (exp_q[0] !== 32'(c)) begin
                    n_fail++; $display("FAIL b2b_shift: got cycle %0d expected %0d", c, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            if (result_latch === 1'b1) latches++;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_shift: %0d pulses not seen, expected 0", exp_q.size()); end
        n_checks++; if (latches != 3) begin n_fail++; $display("FAIL b2b_latch_count: got %0d expected 3", latches); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        begin
            int w;
            w = 0;
            while (!(state_dbg === S_IDLE && out_valid === 1'b0) && w < 100) begin
                tick();
                w++;
            end
            n_checks++; if (w >= 100) begin n_fail++; $display("FAIL b2b_drain: timeout state=%0d out_valid=%b expected idle/0", state_dbg, out_valid); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        int t;
        out_ready  = 1'b1;
        // stall in IDLE: a presented sample must not be taken
        clk_enable = 1'b0;
        in_valid   = 1'b1;
        #1;
        n_checks++; if (shift_en !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_idle: shift_en=%b in_ready=%b expected 0 1", shift_en, in_ready); end
        tick();
        n_checks++; if (state_dbg !== S_IDLE) begin n_fail++; $display("FAIL stall_idle_hold: got %0d expected %0d", state_dbg, S_IDLE); end
        clk_enable = 1'b1;
        #1;
        n_checks++; if (shift_en !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %b expected 1", shift_en); end
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        clk_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (phase !== 6'd20 || state_dbg !== S_RUN) begin n_fail++; $display("FAIL stall_hold i=%0d: phase=%0d state=%0d expected 20 %0d", i, phase, state_dbg, S_RUN); end
            n_checks++; if ({shift_en, acc_clear, result_latch, acc_en} !== '0) begin n_fail++; $display("FAIL stall_strobes i=%0d: got %b%b%b %h expected all 0", i, shift_en, acc_clear, result_latch, acc_en); end
            tick();
        end
        clk_enable = 1'b1;
        t = 26;
        #1;
        while (result_latch !== 1'b1 && t < 200) begin
            tick();
            t++;
            #1;
        end
        n_checks++; if (t != PHASES + 1 + 5) begin n_fail++; $display("FAIL stall_latency: got %0d expected %0d", t, PHASES + 6); end
        tick();
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int t;
        pulse_reset();
        out_ready = 1'b0;
        start_and_wait(t);
        n_checks++; if (t != PHASES + 1) begin n_fail++; $display("FAIL ovr_latency1: got %0d expected %0d", t, PHASES + 1); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first: out_valid=%b overrun=%b expected 1 0", out_valid, overrun); end
        start_and_wait(t);
        n_checks++; if (t != PHASES + 1) begin n_fail++; $display("FAIL ovr_latency2: got %0d expected %0d", t, PHASES + 1); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        tick();
        n_checks++; if (overrun !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_set: overrun=%b out_valid=%b expected 1 1", overrun, out_valid); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: out_valid=%b overrun=%b expected 0 1", out_valid, overrun); end
        out_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        int t;
        pulse_reset();
        out_ready = 1'b0;
        start_and_wait(t);
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sim_first: got %b expected 1", out_valid); end
        start_and_wait(t);
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL sim_latch_consume: out_valid=%b overrun=%b expected 1 0", out_valid, overrun); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sim_then_consume: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int t;
        int latches;
        pulse_reset();
        out_ready = 1'b0;
        start_and_wait(t);
        tick();
        in_valid = 1'b1;
        #1;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        n_checks++; if (phase !== 6'd30 || state_dbg !== S_RUN || out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: phase=%0d state=%0d out_valid=%b expected 30 %0d 1", phase, state_dbg, out_valid, S_RUN); end
        reset = 1'b0;
        tick();
        n_checks++; if (state_dbg !== S_IDLE || phase !== 6'd0) begin n_fail++; $display("FAIL mid_reset_state: state=%0d phase=%0d expected %0d 0", state_dbg, phase, S_IDLE); end
        n_checks++; if (out_valid !== 1'b0 || result_latch !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_outs: out_valid=%b latch=%b in_ready=%b expected 0 0 1", out_valid, result_latch, in_ready); end
        reset = 1'b1;
        latches = 0;
        for (int i = 0; i < PHASES + 10; i++) begin
            #1;
            if (result_latch === 1'b1) latches++;
            tick();
        end
        n_checks++; if (latches != 0 || state_dbg !== S_IDLE) begin n_fail++; $display("FAIL mid_no_latch: latches=%0d state=%0d expected 0 %0d", latches, state_dbg, S_IDLE); end
    endtask

`ifdef FB_SCHED_BAND_MASK_EN
    task automatic test_band_mask();
        band_mask = 16'h00FF;
        in_valid  = 1'b1;
        #1;
        tick();
        in_valid  = 1'b0;
        band_mask = 16'hFFFF;  // late change must not affect this sample
        for (int p = 0; p < PHASES; p++) begin
            #1;
            n_checks++; if (acc_en !== 16'h00FF) begin n_fail++; $display("FAIL mask_acc_en p=%0d: got %h expected 00ff", p, acc_en); end
            tick();
        end
        tick();
        tick();
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overrun();
        test_simultaneous();
        test_reset_mid_run();
`ifdef FB_SCHED_BAND_MASK_EN
        test_band_mask();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
